// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the PC, IF/ID, ID/EX and EX/MEM pipeline registers: load-use stalls, EX redirects, dmem waits, forwarding.
// Optional perf counters (stall_cycles, flush_count) are built only when HAZARD_PERF_COUNT_EN is defined.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_WIDTH        = 5,
    parameter int LOAD_USE_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT           = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_usesRs,
    input  logic                      id_usesRt,
    input  logic [REG_ADDR_WIDTH-1:0] ex_writeReg,
    input  logic                      ex_shouldWriteRegister,
    input  logic                      ex_isLoad,
    input  logic                      ex_redirect,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] mem_writeReg,
    input  logic                      mem_shouldWriteRegister,
    input  logic [REG_ADDR_WIDTH-1:0] wb_writeReg,
    input  logic                      wb_shouldWriteRegister,
    input  logic                      dmem_request,
    input  logic                      dmem_ready,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      ifid_flush,
    output logic                      idex_write,
    output logic                      idex_flush,
    output logic                      exmem_write,
    output logic [1:0]                forward_rs_sel,
    output logic [1:0]                forward_rt_sel,
    output logic                      mem_error,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_count
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} stateType;

    localparam logic [1:0] STALL_INIT    = 2'(LOAD_USE_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    stateType stateReg, stateNext, savedStateReg, savedStateNext, effState;
    logic [1:0] remainingReg, remainingNext, savedRemainingReg, savedRemainingNext, effRemaining;
    logic [7:0] timeoutReg, timeoutNext;
    logic       memErrorReg, memErrorNext;
    logic       hazard, memWait;
    logic       pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite;

    assign hazard = ex_isLoad && ex_shouldWriteRegister && (ex_writeReg != '0) &&
                    ((id_usesRs && (id_rs == ex_writeReg)) || (id_usesRt && (id_rt == ex_writeReg)));
    assign memWait = dmem_request && !dmem_ready;

    // On the ready cycle the frozen context is resumed as if the wait never happened.
    assign effState     = (stateReg == MEM_WAIT) ? savedStateReg : stateReg;
    assign effRemaining = (stateReg == MEM_WAIT) ? savedRemainingReg : remainingReg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg          <= RUN;
            savedStateReg     <= RUN;
            remainingReg      <= '0;
            savedRemainingReg <= '0;
            timeoutReg        <= '0;
            memErrorReg       <= 1'b0;
        end else begin
            stateReg          <= stateNext;
            savedStateReg     <= savedStateNext;
            remainingReg      <= remainingNext;
            savedRemainingReg <= savedRemainingNext;
            timeoutReg        <= timeoutNext;
            memErrorReg       <= memErrorNext;
        end
    end

    always_comb begin
        pcWrite            = 1'b1;
        ifidWrite          = 1'b1;
        ifidFlush          = 1'b0;
        idexWrite          = 1'b1;
        idexFlush          = 1'b0;
        exmemWrite         = 1'b1;
        stateNext          = RUN;
        remainingNext      = '0;
        savedStateNext     = savedStateReg;
        savedRemainingNext = savedRemainingReg;
        if (memWait) begin
            pcWrite       = 1'b0;
            ifidWrite     = 1'b0;
            idexWrite     = 1'b0;
            exmemWrite    = 1'b0;
            stateNext     = MEM_WAIT;
            remainingNext = remainingReg;
            if (stateReg != MEM_WAIT) begin
                savedStateNext     = stateReg;
                savedRemainingNext = remainingReg;
            end
        end else if (ex_redirect) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (effState == LOAD_STALL) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
            if (effRemaining > 2'd1) begin
                stateNext     = LOAD_STALL;
                remainingNext = effRemaining - 2'd1;
            end
        end else if (hazard) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
            if (LOAD_USE_STALL_CYCLES > 1) begin
                stateNext     = LOAD_STALL;
                remainingNext = STALL_INIT;
            end
        end
    end

    always_comb begin
        timeoutNext  = '0;
        memErrorNext = memErrorReg;
        if (memWait) begin
            timeoutNext = (timeoutReg == 8'hFF) ? 8'hFF : timeoutReg + 8'd1;
            if (timeoutNext >= TIMEOUT_LIMIT) begin
                memErrorNext = 1'b1;
            end
        end
    end

    // Index 0 is rs, index 1 is rt; the EX/MEM match outranks MEM/WB.
    logic [1:0][REG_ADDR_WIDTH-1:0] exSrc;
    logic [1:0][1:0]                fwdSel;
    assign exSrc[0] = ex_rs;
    assign exSrc[1] = ex_rt;
    for (genvar gi = 0; gi < 2; gi++) begin : gForward
        assign fwdSel[gi] =
            (mem_shouldWriteRegister && (mem_writeReg != '0) && (mem_writeReg == exSrc[gi])) ? 2'd1 :
            (wb_shouldWriteRegister  && (wb_writeReg  != '0) && (wb_writeReg  == exSrc[gi])) ? 2'd2 :
            2'd0;
    end

    // While reset is held the pipeline is frozen and both stage registers are forced to bubbles.
    assign pc_write       = reset_n && pcWrite;
    assign ifid_write     = reset_n && ifidWrite;
    assign ifid_flush     = !reset_n || ifidFlush;
    assign idex_write     = reset_n && idexWrite;
    assign idex_flush     = !reset_n || idexFlush;
    assign exmem_write    = reset_n && exmemWrite;
    assign forward_rs_sel = reset_n ? fwdSel[0] : 2'd0;
    assign forward_rt_sel = reset_n ? fwdSel[1] : 2'd0;
    assign mem_error      = memErrorReg;

`ifdef HAZARD_PERF_COUNT_EN
    logic [31:0] stallCyclesReg, flushCountReg;
    logic        redirectCycle;
    assign redirectCycle = !memWait && ex_redirect;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCyclesReg <= '0;
            flushCountReg  <= '0;
        end else begin
            if (!pcWrite) begin
                stallCyclesReg <= stallCyclesReg + 32'd1;
            end
            if (redirectCycle) begin
                flushCountReg <= flushCountReg + 32'd1;
            end
        end
    end
    assign stall_cycles = stallCyclesReg;
    assign flush_count  = flushCountReg;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: instance A uses default parameters, instance B uses 3 load-use bubbles and a 3-cycle memory timeout.
module tb_pipeline_hazard_controller;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic [4:0] id_rs, id_rt, ex_writeReg, ex_rs, ex_rt, mem_writeReg, wb_writeReg;
    logic       id_usesRs, id_usesRt, ex_shouldWriteRegister, ex_isLoad, ex_redirect;
    logic       mem_shouldWriteRegister, wb_shouldWriteRegister, dmem_request, dmem_ready;

    logic        pcWriteA, ifidWriteA, ifidFlushA, idexWriteA, idexFlushA, exmemWriteA, memErrorA;
    logic        pcWriteB, ifidWriteB, ifidFlushB, idexWriteB, idexFlushB, exmemWriteB, memErrorB;
    logic [1:0]  fwdRsA, fwdRtA, fwdRsB, fwdRtB;
    logic [31:0] stallA, flushA, stallB, flushB;
    logic [5:0]  ctlA, ctlB;

    // Control vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write
    assign ctlA = {pcWriteA, ifidWriteA, ifidFlushA, idexWriteA, idexFlushA, exmemWriteA};
    assign ctlB = {pcWriteB, ifidWriteB, ifidFlushB, idexWriteB, idexFlushB, exmemWriteB};

    localparam logic [5:0] NRM = 6'b110101;
    localparam logic [5:0] STL = 6'b000111;
    localparam logic [5:0] RDR = 6'b111111;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] RST = 6'b001010;

    pipeline_hazard_controller dutA (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
        .ex_writeReg(ex_writeReg), .ex_shouldWriteRegister(ex_shouldWriteRegister),
        .ex_isLoad(ex_isLoad), .ex_redirect(ex_redirect), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_writeReg(mem_writeReg), .mem_shouldWriteRegister(mem_shouldWriteRegister),
        .wb_writeReg(wb_writeReg), .wb_shouldWriteRegister(wb_shouldWriteRegister),
        .dmem_request(dmem_request), .dmem_ready(dmem_ready),
        .pc_write(pcWriteA), .ifid_write(ifidWriteA), .ifid_flush(ifidFlushA),
        .idex_write(idexWriteA), .idex_flush(idexFlushA), .exmem_write(exmemWriteA),
        .forward_rs_sel(fwdRsA), .forward_rt_sel(fwdRtA), .mem_error(memErrorA),
        .stall_cycles(stallA), .flush_count(flushA)
    );

    pipeline_hazard_controller #(.LOAD_USE_STALL_CYCLES(3), .MEM_TIMEOUT(3)) dutB (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
        .ex_writeReg(ex_writeReg), .ex_shouldWriteRegister(ex_shouldWriteRegister),
        .ex_isLoad(ex_isLoad), .ex_redirect(ex_redirect), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_writeReg(mem_writeReg), .mem_shouldWriteRegister(mem_shouldWriteRegister),
        .wb_writeReg(wb_writeReg), .wb_shouldWriteRegister(wb_shouldWriteRegister),
        .dmem_request(dmem_request), .dmem_ready(dmem_ready),
        .pc_write(pcWriteB), .ifid_write(ifidWriteB), .ifid_flush(ifidFlushB),
        .idex_write(idexWriteB), .idex_flush(idexFlushB), .exmem_write(exmemWriteB),
        .forward_rs_sel(fwdRsB), .forward_rt_sel(fwdRtB), .mem_error(memErrorB),
        .stall_cycles(stallB), .flush_count(flushB)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setIdle();
        id_rs = '0; id_rt = '0; id_usesRs = 1'b0; id_usesRt = 1'b0;
        ex_writeReg = '0; ex_shouldWriteRegister = 1'b0; ex_isLoad = 1'b0; ex_redirect = 1'b0;
        ex_rs = '0; ex_rt = '0;
        mem_writeReg = '0; mem_shouldWriteRegister = 1'b0;
        wb_writeReg = '0; wb_shouldWriteRegister = 1'b0;
        dmem_request = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic setHazard(input logic [4:0] r, input logic viaRt);
        setIdle();
        ex_isLoad = 1'b1; ex_shouldWriteRegister = 1'b1; ex_writeReg = r;
        if (viaRt) begin
            id_rt = r; id_usesRt = 1'b1;
        end else begin
            id_rs = r; id_usesRs = 1'b1;
        end
    endtask

    // Inputs are applied just after a rising edge; outputs are checked on the falling edge.
    task automatic step(input string tag, input logic [5:0] expA, input logic [5:0] expB, input logic expErrB);
        @(negedge clock);
        chk({tag, "/ctlA"}, 32'(ctlA), 32'(expA));
        chk({tag, "/ctlB"}, 32'(ctlB), 32'(expB));
        chk({tag, "/memErrA"}, 32'(memErrorA), 32'd0);
        chk({tag, "/memErrB"}, 32'(memErrorB), 32'(expErrB));
        $display("step %s ctlA=%b ctlB=%b memErrB=%b", tag, ctlA, ctlB, memErrorB);
        @(posedge clock); #1;
    endtask

    task automatic fwdStep(input string tag, input logic [1:0] expRs, input logic [1:0] expRt);
        @(negedge clock);
        chk({tag, "/rsA"}, 32'(fwdRsA), 32'(expRs));
        chk({tag, "/rtA"}, 32'(fwdRtA), 32'(expRt));
        chk({tag, "/rsB"}, 32'(fwdRsB), 32'(expRs));
        chk({tag, "/rtB"}, 32'(fwdRtB), 32'(expRt));
        $display("fwd %s rs=%0d rt=%0d", tag, fwdRsA, fwdRtA);
        @(posedge clock); #1;
    endtask

    initial begin
        setIdle();
        reset_n = 1'b0;
        #2;
        chk("rst/ctlA", 32'(ctlA), 32'(RST));
        chk("rst/ctlB", 32'(ctlB), 32'(RST));
        chk("rst/fwdA", 32'({fwdRsA, fwdRtA}), 32'd0);
        chk("rst/memErrB", 32'(memErrorB), 32'd0);
        chk("rst/stallA", stallA, 32'd0);
        chk("rst/flushA", flushA, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Hazard qualification and load-use stall length
        setIdle();                  step("idle", NRM, NRM, 1'b0);
        setHazard(5'd0, 1'b0);      step("r0NoHaz", NRM, NRM, 1'b0);
        setIdle(); ex_shouldWriteRegister = 1'b1; ex_writeReg = 5'd5; id_rs = 5'd5; id_usesRs = 1'b1;
                                    step("nonLoad", NRM, NRM, 1'b0);
        setHazard(5'd5, 1'b1); id_usesRt = 1'b0;
                                    step("rtUnused", NRM, NRM, 1'b0);
        setHazard(5'd5, 1'b0);      step("haz1", STL, STL, 1'b0);
        setIdle();                  step("haz2", NRM, STL, 1'b0);
                                    step("haz3", NRM, STL, 1'b0);
                                    step("hazEnd", NRM, NRM, 1'b0);

        // Redirect in the 2nd LOAD_STALL cycle
        setHazard(5'd9, 1'b1);      step("rdHaz", STL, STL, 1'b0);
        setIdle(); ex_redirect = 1'b1;
                                    step("rdAbort", RDR, RDR, 1'b0);
        setIdle();                  step("rdAfter", NRM, NRM, 1'b0);

        // Memory wait: 4 frozen cycles, B times out on its 3rd
        setIdle(); dmem_request = 1'b1;
                                    step("wait1", FRZ, FRZ, 1'b0);
                                    step("wait2", FRZ, FRZ, 1'b0);
                                    step("wait3", FRZ, FRZ, 1'b0);
                                    step("wait4", FRZ, FRZ, 1'b1);
        dmem_ready = 1'b1;          step("ready", NRM, NRM, 1'b1);
        setIdle();                  step("sticky", NRM, NRM, 1'b1);

        // Wait during LOAD_STALL resumes the remaining bubbles
        setHazard(5'd12, 1'b0);     step("wsHaz", STL, STL, 1'b1);
        setIdle(); dmem_request = 1'b1;
                                    step("wsWait1", FRZ, FRZ, 1'b1);
                                    step("wsWait2", FRZ, FRZ, 1'b1);
        dmem_ready = 1'b1;          step("wsReady", NRM, STL, 1'b1);
        setIdle();                  step("wsLast", NRM, STL, 1'b1);
                                    step("wsDone", NRM, NRM, 1'b1);

        // Redirect held through a freeze takes effect on the ready cycle
        setIdle(); dmem_request = 1'b1; ex_redirect = 1'b1;
                                    step("wrWait", FRZ, FRZ, 1'b1);
        dmem_ready = 1'b1;          step("wrReady", RDR, RDR, 1'b1);
        setIdle();                  step("wrAfter", NRM, NRM, 1'b1);

        // Forwarding priority
        setIdle(); mem_writeReg = 5'd7; mem_shouldWriteRegister = 1'b1;
        wb_writeReg = 5'd7; wb_shouldWriteRegister = 1'b1; ex_rs = 5'd7; ex_rt = 5'd3;
                                    fwdStep("fwdMem", 2'd1, 2'd0);
        mem_writeReg = 5'd0;        fwdStep("fwdWb", 2'd2, 2'd0);
        mem_writeReg = 5'd7; ex_rs = 5'd0; ex_rt = 5'd7;
                                    fwdStep("fwdZero", 2'd0, 2'd1);
        mem_writeReg = 5'd3; mem_shouldWriteRegister = 1'b0; wb_writeReg = 5'd3; ex_rs = 5'd7; ex_rt = 5'd3;
                                    fwdStep("fwdRtWb", 2'd0, 2'd2);

        // Asynchronous reset in the middle of a LOAD_STALL
        setHazard(5'd5, 1'b0);      step("rsHaz", STL, STL, 1'b1);
        setIdle(); mem_writeReg = 5'd7; mem_shouldWriteRegister = 1'b1; ex_rs = 5'd7;
        #1 reset_n = 1'b0;
        #1;
        chk("midRst/ctlA", 32'(ctlA), 32'(RST));
        chk("midRst/ctlB", 32'(ctlB), 32'(RST));
        chk("midRst/fwdRsB", 32'(fwdRsB), 32'd0);
        chk("midRst/memErrB", 32'(memErrorB), 32'd0);
        $display("midRst ctlA=%b ctlB=%b", ctlA, ctlB);
        @(posedge clock);
        @(negedge clock);
        setIdle();
        reset_n = 1'b1;
        @(posedge clock); #1;
                                    step("postRst", NRM, NRM, 1'b0);
        chk("postRst/stallB", stallB, 32'd0);
        chk("postRst/flushB", flushB, 32'd0);

        // Perf counters: two load-use stalls and one redirect
        setHazard(5'd4, 1'b0);      step("pf1", STL, STL, 1'b0);
        setIdle();                  step("pf2", NRM, STL, 1'b0);
                                    step("pf3", NRM, STL, 1'b0);
                                    step("pf4", NRM, NRM, 1'b0);
        setHazard(5'd6, 1'b1);      step("pf5", STL, STL, 1'b0);
        setIdle();                  step("pf6", NRM, STL, 1'b0);
                                    step("pf7", NRM, STL, 1'b0);
                                    step("pf8", NRM, NRM, 1'b0);
        ex_redirect = 1'b1;         step("pf9", RDR, RDR, 1'b0);
        setIdle();
        @(negedge clock);
`ifdef HAZARD_PERF_COUNT_EN
        chk("perf/stallA", stallA, 32'd2);
        chk("perf/flushA", flushA, 32'd1);
        chk("perf/stallB", stallB, 32'd6);
        chk("perf/flushB", flushB, 32'd1);
`else
        chk("perf/stallA", stallA, 32'd0);
        chk("perf/flushA", flushA, 32'd0);
        chk("perf/stallB", stallB, 32'd0);
        chk("perf/flushB", flushB, 32'd0);
`endif
        $display("perf stallA=%0d flushA=%0d stallB=%0d flushB=%0d", stallA, flushA, stallB, flushB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM).
- Detects load-use hazards, EX-stage control redirects (taken branch/jump) and data-memory wait states.
- Drives write-enable, flush and forwarding selects for those registers from a small state machine.
- Sits beside the decode stage; its inputs are stage-tagged fields from the ID, EX and MEM pipeline registers.

Parameters:
- REG_ADDR_WIDTH, 5: register-file address width.
- LOAD_USE_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..3.
- MEM_TIMEOUT, 255: MEM_WAIT cycles before mem_error is raised; 8-bit counter.

Ports:
- clock in 1: rising-edge clock.
- reset_n in 1: asynchronous, active-low reset.
- id_rs in REG_ADDR_WIDTH: rs address of the instruction in ID.
- id_rt in REG_ADDR_WIDTH: rt address of the instruction in ID.
- id_usesRs in 1: ID instruction reads rs.
- id_usesRt in 1: ID instruction reads rt.
- ex_writeReg in REG_ADDR_WIDTH: destination register in EX.
- ex_shouldWriteRegister in 1: EX instruction writes a register.
- ex_isLoad in 1: EX instruction is a load.
- ex_redirect in 1: EX resolved a taken branch or jump this cycle.
- ex_rs in REG_ADDR_WIDTH, ex_rt in REG_ADDR_WIDTH: EX source addresses, used for forwarding.
- mem_writeReg in REG_ADDR_WIDTH, mem_shouldWriteRegister in 1: MEM-stage destination register and write flag.
- wb_writeReg in REG_ADDR_WIDTH, wb_shouldWriteRegister in 1: WB-stage destination register and write flag.
- dmem_request in 1: MEM stage is accessing data memory.
- dmem_ready in 1: data memory completes the access this cycle.
- pc_write out 1: PC load enable.
- ifid_write out 1: IF/ID load enable.
- ifid_flush out 1: IF/ID loads a NOP.
- idex_write out 1: ID/EX load enable.
- idex_flush out 1: ID/EX loads a bubble (all controls 0).
- exmem_write out 1: EX/MEM load enable.
- forward_rs_sel out 2: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- forward_rt_sel out 2: same encoding as forward_rs_sel.
- mem_error out 1: sticky memory-timeout flag.
- stall_cycles out 32: perf counter (see Optional Feature).
- flush_count out 32: perf counter (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = RUN; counters = 0; mem_error = 0.
  - pc_write = ifid_write = idex_write = exmem_write = 0.
  - ifid_flush = idex_flush = 1.
  - forward selects = 0.
- Outputs are a combinational decode of the state and current inputs. State, counters and mem_error are registered.
- States: RUN, LOAD_STALL, MEM_WAIT.
- hazard = ex_isLoad & ex_shouldWriteRegister & (ex_writeReg != 0) & ((id_usesRs & id_rs == ex_writeReg) | (id_usesRt & id_rt == ex_writeReg)).
- wait = dmem_request & !dmem_ready.
- Priority is wait > ex_redirect > hazard > normal.
- wait (any state):
  - All write enables = 0; no flushes.
  - Next state = MEM_WAIT. The prior state is saved, including the LOAD_STALL remaining count.
- MEM_WAIT:
  - Hold everything frozen while wait is true. The timeout counter increments, saturating at 255.
  - Reaching MEM_TIMEOUT sets mem_error; it clears only on reset.
  - When dmem_ready arrives, that cycle is evaluated with normal priority, and the state returns to the saved state. The timeout counter clears.
  - A redirect held in EX during the freeze takes effect on the ready cycle.
- ex_redirect (not waiting):
  - pc_write = 1, ifid_flush = 1, idex_flush = 1, exmem_write = 1.
  - Aborts LOAD_STALL; next state = RUN.
- hazard in RUN:
  - pc_write = 0, ifid_write = 0, idex_flush = 1, exmem_write = 1.
  - If LOAD_USE_STALL_CYCLES > 1, go to LOAD_STALL with remaining = LOAD_USE_STALL_CYCLES - 1.
- LOAD_STALL:
  - Same outputs as the hazard cycle. remaining decrements each cycle.
  - Return to RUN after the cycle in which remaining reaches 0.
- Normal operation: all write enables = 1, flushes = 0.
- Forwarding (combinational, all states), shown for rs; rt is identical:
  - If mem_shouldWriteRegister & mem_writeReg != 0 & mem_writeReg == ex_rs, select 1.
  - Else if the same test holds for WB, select 2.
  - Else select 0.
  - EX/MEM wins over MEM/WB.
- Register 0 never triggers a hazard or a forward.

Optional Feature:
- Macro: HAZARD_PERF_COUNT_EN.
- Defined:
  - stall_cycles increments on each cycle with pc_write = 0 and reset_n high.
  - flush_count increments on each redirect cycle.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
1. Load-use hazard: load to r5 in EX, ID reads r5 via rs, default parameters -> exactly 1 cycle of pc_write = 0 and idex_flush = 1, then normal flow; with LOAD_USE_STALL_CYCLES = 3 -> 3 stall cycles.
2. Redirect during stall: ex_redirect asserted in the 2nd LOAD_STALL cycle (LOAD_USE_STALL_CYCLES = 3) -> that cycle pc_write = 1 and ifid_flush = idex_flush = 1; state RUN next cycle.
3. Memory wait: dmem_request = 1 with dmem_ready low for 4 cycles -> all write enables 0 for 4 cycles and normal on the 5th; with MEM_TIMEOUT = 3 and a 5-cycle wait -> mem_error = 1 and it stays set.
4. Forwarding priority: mem_writeReg = wb_writeReg = 7, ex_rs = 7, both write flags set -> forward_rs_sel = 1; with mem_writeReg = 0 -> forward_rs_sel = 2; with ex_rs = 0 -> 0.
5. Reset mid-stall: reset_n pulsed low during LOAD_STALL -> outputs immediately take reset values; after release, state is RUN and counters are 0.
6. Perf counters (HAZARD_PERF_COUNT_EN defined): 2 load-use stalls plus 1 redirect -> stall_cycles = 2, flush_count = 1; with the macro undefined, both read 0.
